mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Parametrised round-robin arbiter between NPORTS cache-side requesters (icache/dcache of each core) and the single RAM port.
- Sits between the per-core caches and the RAM controller in the multicore build, replacing the single-requester request path.
- Each access has a per-access watchdog; the arbiter returns a one-cycle hit or error pulse to the winning port.

## Interface
Parameters:
- NPORTS, 4, number of requesters (≥2)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles an access may stay outstanding before forced error (≥1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-high reset (asserted = 1)
- ren  in  NPORTS  per-port read request
- wen  in  NPORTS  per-port write request
- addr  in  NPORTS*AW  per-port address; port i at [i*AW +: AW]
- store  in  NPORTS*DW  per-port write data; port i at [i*DW +: DW]
- hit  out  NPORTS  one-hot, one-cycle completion pulse
- err  out  NPORTS  one-hot, one-cycle error pulse (RAM ERROR or timeout)
- load  out  DW  read data, valid while hit is high
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  AW  RAM address
- ramstore  out  DW  RAM write data
- ramload  in  DW  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- State: 2-state FSM IDLE/OWN, owner index (clog2(NPORTS) bits), round-robin pointer ptr, watchdog counter wcnt (clog2(TIMEOUT+1) bits).
- Request on port i: req[i] = ren[i] | wen[i]. If both are set, the access is a write.
- IDLE, any req:
  - Select the first requesting port searching ptr, ptr+1, … modulo NPORTS.
  - Latch owner, op (write if wen), addr and store of that port.
  - Clear wcnt and go to OWN.
- IDLE, no req: no change; ram enables low.
- OWN:
  - ramREN/ramWEN from latched op; ramaddr/ramstore from latched values.
  - Each cycle in OWN, evaluate in this priority order:
    - ramstate == ACCESS: hit[owner]=1, load=ramload (combinational, same cycle). ptr <= owner+1 mod NPORTS; go IDLE.
    - ramstate == ERROR: err[owner]=1. ptr <= owner+1; go IDLE.
    - Owner drops its req (ren and wen both 0): abort, no hit/err. ptr <= owner+1; go IDLE.
    - wcnt == TIMEOUT-1: err[owner]=1. ptr <= owner+1; go IDLE.
    - Otherwise: wcnt increments.
- Changes to a non-owner's addr/store during OWN have no effect. Owner's addr/store are latched and not re-sampled.
- Outside OWN: hit, err, ramREN and ramWEN are all 0. load = 0 unless hit is high.
- Fairness: a continuously requesting port is granted within NPORTS-1 other grants.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, ptr=0, owner=0, wcnt=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - hit=0, err=0, load=0.
- Reset mid-access: the access is dropped with no hit/err. The RAM sees enables fall in the same cycle reset asserts.
- Latency: req first seen in IDLE at cycle t → RAM enables at t+1 → hit in the first OWN cycle with ACCESS. Minimum 1 cycle from grant to hit; the earliest hit is at t+1.
- Throughput: one mandatory IDLE cycle after every completion, so at most one access per 2 cycles.
- Timeout: err fires in the TIMEOUT-th OWN cycle if no ACCESS/ERROR arrived. ACCESS in that same cycle wins (hit, not err).
- Requester must hold req until hit/err. hit/err last exactly one cycle; the requester may drop or re-assert req the next cycle.
- ptr wrap: owner NPORTS-1 → ptr 0.

## Test plan
- Reset: assert nRST mid-OWN with ramREN=1 → all outputs 0 immediately. After release, ptr=0, so port 0 wins the next simultaneous request.
- Single read: port 2 ren, addr=0x40, ramstate ACCESS on 3rd OWN cycle with ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40 for 3 cycles; hit=0100 and load=0xDEADBEEF in the 3rd cycle.
- Round-robin: all 4 ports request continuously with ACCESS immediate → grant order 0,1,2,3,0, each hit separated by one IDLE cycle.
- Write priority: port 1 ren=wen=1, store=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234.
- Timeout (TIMEOUT=4): ramstate held BUSY → err[owner] on the 4th OWN cycle, then IDLE, ptr=owner+1. Same run with ACCESS on cycle 4 → hit, no err.
- Abort/error: owner drops req in 2nd OWN cycle → IDLE next cycle, no pulse. ramstate ERROR → err pulse only, load=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side request bus and RAM-side port of the multicore memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
);
  logic [NPORTS-1:0]    ren;
  logic [NPORTS-1:0]    wen;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] store;
  logic [NPORTS-1:0]    hit;
  logic [NPORTS-1:0]    err;
  logic [DW-1:0]        load;
  logic                 ramREN;
  logic                 ramWEN;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore;
  logic [DW-1:0]        ramload;
  logic [1:0]           ramstate;

  modport slave (
    input  ren, wen, addr, store, ramload, ramstate,
    output hit, err, load, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output ren, wen, addr, store, ramload, ramstate,
    input  hit, err, load, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of NPORTS cache requesters the single RAM
// port, with a per-access watchdog that forces an error after TIMEOUT cycles.
module mem_arbiter #(
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam int unsigned OW  = $clog2(NPORTS);
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         r_state, w_state_nxt;
  logic [OW-1:0]  r_owner, w_owner_nxt;
  logic [OW-1:0]  r_ptr, w_ptr_nxt;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;
  logic           r_wr, w_wr_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic [DW-1:0]  r_store, w_store_nxt;

  logic [NPORTS-1:0] w_req;
  logic [NPORTS-1:0] w_hit;
  logic [NPORTS-1:0] w_err;
  logic [DW-1:0]     w_load;
  logic              w_ren;
  logic              w_wen;
  logic              w_found;
  logic [OW-1:0]     w_pick;
  logic [OW-1:0]     w_idx;
  logic [OW-1:0]     w_ptr_inc;
  logic [AW-1:0]     w_port_addr  [NPORTS];
  logic [DW-1:0]     w_port_store [NPORTS];

  assign w_req = bus.ren | bus.wen;

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign w_port_addr[g]  = bus.addr[g*AW +: AW];
    assign w_port_store[g] = bus.store[g*DW +: DW];
  end

  assign w_ptr_inc = OW'((32'(r_owner) + 32'd1) % NPORTS);

  // First requester at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      w_idx = OW'((32'(r_ptr) + k) % NPORTS);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_wcnt  <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_store <= w_store_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_wcnt_nxt  = r_wcnt;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_store_nxt = r_store;
    w_hit       = '0;
    w_err       = '0;
    w_load      = '0;
    w_ren       = 1'b0;
    w_wen       = 1'b0;

    if (r_state == IDLE) begin
      if (w_found) begin
        w_state_nxt = OWN;
        w_owner_nxt = w_pick;
        w_wr_nxt    = bus.wen[w_pick];
        w_addr_nxt  = w_port_addr[w_pick];
        w_store_nxt = w_port_store[w_pick];
        w_wcnt_nxt  = '0;
      end
    end else begin
      w_ren = !r_wr;
      w_wen = r_wr;
      // RAM completion outranks an owner abort, which outranks the watchdog.
      if (bus.ramstate == RS_ACCESS) begin
        w_hit[r_owner] = 1'b1;
        w_load         = bus.ramload;
        w_ptr_nxt      = w_ptr_inc;
        w_state_nxt    = IDLE;
      end else if (bus.ramstate == RS_ERROR) begin
        w_err[r_owner] = 1'b1;
        w_ptr_nxt      = w_ptr_inc;
        w_state_nxt    = IDLE;
      end else if (!w_req[r_owner]) begin
        w_ptr_nxt   = w_ptr_inc;
        w_state_nxt = IDLE;
      end else if (r_wcnt == WCW'(TIMEOUT - 1)) begin
        w_err[r_owner] = 1'b1;
        w_ptr_nxt      = w_ptr_inc;
        w_state_nxt    = IDLE;
      end else begin
        w_wcnt_nxt = r_wcnt + WCW'(1);
      end
    end
  end

  assign bus.hit      = w_hit;
  assign bus.err      = w_err;
  assign bus.load     = w_load;
  assign bus.ramREN   = w_ren;
  assign bus.ramWEN   = w_wen;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// requester/RAM traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK  (clk),
    .nRST (rst),
    .bus  (bus)
  );

  int n_checks;
  int n_errors;

  // Reference model: one outstanding access, its age in OWN cycles, rr pointer.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_age;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic [3:0]  m_pulse;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_age   = 0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_store = '0;
    m_pulse = '0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] s);
    bus.ren[p]          = r;
    bus.wen[p]          = w;
    bus.addr[p*AW +: AW] = a;
    bus.store[p*DW +: DW] = s;
  endtask

  task automatic clr_reqs();
    bus.ren = '0;
    bus.wen = '0;
  endtask

  // Called at a falling edge with inputs applied; checks this cycle, advances model.
  task automatic step();
    logic [3:0]  req, e_hit, e_err;
    logic [31:0] e_load, e_addr, e_store;
    bit          e_ren, e_wen, done, granted;
    req = bus.ren | bus.wen;
    e_hit = '0; e_err = '0; e_load = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = m_addr; e_store = m_store;
    done = 1'b0; granted = 1'b0;
    #2;
    if (!m_busy) begin
      for (int d = 0; d < NP; d++) begin
        int p;
        p = (m_ptr + d) % NP;
        if (!granted && req[p]) begin
          granted = 1'b1;
          m_busy  = 1'b1;
          m_owner = p;
          m_wr    = bus.wen[p];
          m_addr  = bus.addr[p*AW +: AW];
          m_store = bus.store[p*DW +: DW];
          m_age   = 0;
        end
      end
    end else begin
      e_ren = !m_wr;
      e_wen = m_wr;
      m_age++;
      if (bus.ramstate == RS_ACCESS) begin
        e_hit[m_owner] = 1'b1;
        e_load = bus.ramload;
        done = 1'b1;
      end else if (bus.ramstate == RS_ERROR) begin
        e_err[m_owner] = 1'b1;
        done = 1'b1;
      end else if (!req[m_owner]) begin
        done = 1'b1;
      end else if (m_age == TO) begin
        e_err[m_owner] = 1'b1;
        done = 1'b1;
      end
      if (done) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NP;
      end
    end
    m_pulse = e_hit | e_err;
    check("hit",      bus.hit,      e_hit);
    check("err",      bus.err,      e_err);
    check("load",     bus.load,     e_load);
    check("ramREN",   bus.ramREN,   e_ren);
    check("ramWEN",   bus.ramWEN,   e_wen);
    check("ramaddr",  bus.ramaddr,  e_addr);
    check("ramstore", bus.ramstore, e_store);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    clr_reqs();
    bus.ramstate = RS_FREE;
    repeat (n) step();
  endtask

  bit          pend  [NP];
  bit          pwr   [NP];
  bit          pboth [NP];
  logic [31:0] paddr [NP];
  logic [31:0] pstore[NP];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.ren = '0; bus.wen = '0; bus.addr = '0; bus.store = '0;
    bus.ramload = '0; bus.ramstate = RS_FREE;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hit", bus.hit, 0);
    check("rst_err", bus.err, 0);
    check("rst_ren", bus.ramREN, 0);
    check("rst_wen", bus.ramWEN, 0);
    check("rst_addr", bus.ramaddr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Move ptr off zero, then reset in the middle of an access.
    set_port(1, 1, 0, 32'h10, 0); bus.ramstate = RS_ACCESS;
    step(); step();
    clr_reqs(); step();
    set_port(3, 1, 0, 32'h99, 0); bus.ramstate = RS_BUSY;
    step(); step();
    #1;
    check("pre_rst_ren", bus.ramREN, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ren",   bus.ramREN,   0);
    check("mid_rst_hit",   bus.hit,      0);
    check("mid_rst_err",   bus.err,      0);
    check("mid_rst_load",  bus.load,     0);
    check("mid_rst_addr",  bus.ramaddr,  0);
    check("mid_rst_store", bus.ramstore, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Round robin from ptr 0 with immediate ACCESS: 0,1,2,3,0.
    for (int i = 0; i < NP; i++) set_port(i, 1, 0, 32'h100 + i, 0);
    bus.ramstate = RS_ACCESS;
    bus.ramload  = 32'h5A5A0000;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k % 2 == 1) check("rr_hit", bus.hit, 1 << ((k / 2) % NP));
      else            check("rr_idle", bus.hit, 0);
      step();
    end
    idle(2);

    // Single read on port 2 completing in the third OWN cycle.
    set_port(2, 1, 0, 32'h40, 0); bus.ramstate = RS_BUSY;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin bus.ramstate = RS_ACCESS; bus.ramload = 32'hDEADBEEF; end
      #1;
      check("rd_ren",  bus.ramREN,  1);
      check("rd_addr", bus.ramaddr, 32'h40);
      check("rd_hit",  bus.hit,     (k == 2) ? 4'b0100 : 4'b0000);
      if (k == 2) check("rd_load", bus.load, 32'hDEADBEEF);
      step();
    end
    idle(2);

    // Write wins when both enables are set.
    set_port(1, 1, 1, 32'h80, 32'h1234); bus.ramstate = RS_BUSY;
    step();
    #1;
    check("wr_wen",   bus.ramWEN,   1);
    check("wr_ren",   bus.ramREN,   0);
    check("wr_store", bus.ramstore, 32'h1234);
    step();
    bus.ramstate = RS_ACCESS;
    step();
    idle(2);

    // Watchdog: err in 4th OWN cycle, then ptr = owner+1.
    set_port(0, 1, 0, 32'h200, 0); bus.ramstate = RS_BUSY;
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_err", bus.err, (k == 3) ? 4'b0001 : 4'b0000);
      step();
    end
    clr_reqs();
    for (int i = 0; i < 3; i++) set_port(i, 1, 0, 32'h300 + i, 0);
    bus.ramstate = RS_ACCESS;
    step();
    #1;
    check("to_next_owner", bus.hit, 4'b0010);
    step();
    idle(2);

    // ACCESS in the timeout cycle wins over the watchdog.
    set_port(0, 1, 0, 32'h400, 0); bus.ramstate = RS_BUSY;
    step(); step(); step(); step();
    bus.ramstate = RS_ACCESS; bus.ramload = 32'hCAFE0004;
    #1;
    check("to_access_hit", bus.hit, 4'b0001);
    check("to_access_err", bus.err, 4'b0000);
    step();
    idle(2);

    // Owner abort in the 2nd OWN cycle: no pulse, IDLE next cycle.
    set_port(2, 1, 0, 32'h500, 0); bus.ramstate = RS_BUSY;
    step(); step();
    clr_reqs();
    #1;
    check("abort_hit", bus.hit, 0);
    check("abort_err", bus.err, 0);
    step();
    #1;
    check("abort_idle_ren", bus.ramREN, 0);
    step();

    // RAM ERROR: err pulse only, load stays 0.
    set_port(3, 0, 1, 32'h600, 32'h77); bus.ramstate = RS_BUSY;
    step();
    bus.ramstate = RS_ERROR; bus.ramload = 32'hFFFFFFFF;
    #1;
    check("ramerr_err",  bus.err,  4'b1000);
    check("ramerr_hit",  bus.hit,  0);
    check("ramerr_load", bus.load, 0);
    step();
    idle(2);

    // Randomized traffic: requesters hold until hit/err, occasionally abort.
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int i = 0; i < NP; i++) begin
        if (pend[i] && m_pulse[i]) pend[i] = 1'b0;
        else if (pend[i] && $urandom_range(31) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]   = 1'b1;
          pwr[i]    = 1'($urandom_range(1));
          pboth[i]  = 1'($urandom_range(1));
          paddr[i]  = $urandom;
          pstore[i] = $urandom;
        end
        if (pend[i]) set_port(i, !pwr[i] || pboth[i], pwr[i], paddr[i], pstore[i]);
        else         set_port(i, 0, 0, $urandom, $urandom);
      end
      r = int'($urandom_range(9));
      bus.ramstate = (r < 3) ? RS_BUSY : (r < 6) ? RS_FREE : (r < 9) ? RS_ACCESS : RS_ERROR;
      bus.ramload  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
